// File: rtl/majority_vote_ctrl.sv
// Purpose: sequences one three-voter majority session (IDLE -> COLLECT -> DONE).
// Latency: done strobes 2 edges after start at best; TIMEOUT+1 edges at worst.
// Backpressure: none; start is ignored while busy and is not queued.
module majority_vote_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] vote_en,
    input  logic [2:0] vote_val,
    output logic       busy,
    output logic [2:0] voted,
    output logic       done,
    output logic       pass,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Counter value seen on the last COLLECT edge of a window.
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] cnt;
    logic [2:0]    ballot;

    // Ballots accepted this cycle and the ballot/voted view including them.
    logic [2:0] accept;
    logic [2:0] voted_nxt;
    logic [2:0] ballot_nxt;
    logic [2:0] counted;
    logic [1:0] ones;
    logic       all_voted;
    logic       window_end;

    // Merge this cycle's first-time ballots; repeat strobes are masked by voted.
    always_comb begin
        accept     = vote_en & ~voted;
        voted_nxt  = voted | accept;
        ballot_nxt = (ballot & ~accept) | (vote_val & accept);
        counted    = ballot_nxt & voted_nxt;
        ones       = {1'b0, counted[0]} + {1'b0, counted[1]} + {1'b0, counted[2]};
        all_voted  = (voted_nxt == 3'b111);
        window_end = (cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (all_voted || window_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Session datapath: clear on accepted start, collect ballots, register the verdict on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            ballot  <= '0;
            voted   <= '0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        ballot  <= '0;
                        voted   <= '0;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                COLLECT: begin
                    ballot <= ballot_nxt;
                    voted  <= voted_nxt;
                    // Exit at CNT_LAST happens before the counter could wrap.
                    cnt    <= cnt + 1'b1;
                    if (all_voted || window_end) begin
                        pass    <= (ones >= 2'd2);
                        // A full vote on the final window edge is not a timeout.
                        timeout <= !all_voted;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_majority_vote_ctrl.sv
// Purpose: directed self-checking bench for majority_vote_ctrl with TIMEOUT=15.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: n/a; inputs are driven right after the sampling point.
module tb_majority_vote_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] vote_en;
    logic [2:0] vote_val;
    logic       busy;
    logic [2:0] voted;
    logic       done;
    logic       pass;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    majority_vote_ctrl #(.TIMEOUT(15), .TW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .vote_en  (vote_en),
        .vote_val (vote_val),
        .busy     (busy),
        .voted    (voted),
        .done     (done),
        .pass     (pass),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check the full output set in one call.
    task automatic chk_all(input string tag, input logic b, input logic d,
                           input logic [2:0] v, input logic p, input logic t);
        chk({tag, ".busy"},    {2'b0, busy},    {2'b0, b});
        chk({tag, ".done"},    {2'b0, done},    {2'b0, d});
        chk({tag, ".voted"},   voted,           v);
        chk({tag, ".pass"},    {2'b0, pass},    {2'b0, p});
        chk({tag, ".timeout"}, {2'b0, timeout}, {2'b0, t});
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        vote_en  = 3'b000;
        vote_val = 3'b000;
        tick();
        tick();
        chk_all("reset", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Fastest session: all three vote at E1, values 011 -> pass.
        start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        chk_all("t1.e0", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        vote_en = 3'b111; vote_val = 3'b011;
        tick();                                   // E1
        vote_en = 3'b000;
        chk_all("t1.done", 1'b1, 1'b1, 3'b111, 1'b1, 1'b0);
        tick();                                   // E2
        chk_all("t1.idle", 1'b0, 1'b0, 3'b111, 1'b1, 1'b0);

        // One ballot per cycle: 1, 0, 0 -> fail, no timeout.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t2.e0", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        vote_en = 3'b001; vote_val = 3'b001;
        tick();
        vote_en = 3'b010; vote_val = 3'b000;
        tick();
        chk_all("t2.mid", 1'b1, 1'b0, 3'b011, 1'b0, 1'b0);
        vote_en = 3'b100; vote_val = 3'b000;
        tick();
        vote_en = 3'b000;
        chk_all("t2.done", 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
        tick();
        chk_all("t2.idle", 1'b0, 1'b0, 3'b111, 1'b0, 1'b0);

        // Voters 0 and 2 vote 1; window expires at E15. start pulses during COLLECT and DONE.
        start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        vote_en = 3'b101; vote_val = 3'b101;
        tick();                                   // E1
        vote_en = 3'b000;
        repeat (3) tick();                        // E2..E4
        start = 1'b1;
        tick();                                   // E5: start ignored in COLLECT
        start = 1'b0;
        repeat (8) tick();                        // E6..E13
        start = 1'b1;
        tick();                                   // E14
        chk_all("t3.e14", 1'b1, 1'b0, 3'b101, 1'b0, 1'b0);
        tick();                                   // E15
        chk_all("t3.done", 1'b1, 1'b1, 3'b101, 1'b1, 1'b1);
        tick();                                   // E16: start ignored in DONE
        start = 1'b0;
        chk_all("t3.idle", 1'b0, 1'b0, 3'b101, 1'b1, 1'b1);
        tick();
        chk_all("t3.hold", 1'b0, 1'b0, 3'b101, 1'b1, 1'b1);

        // Re-vote ignored: v1=1 then v1=0, v0=1; timeout with voted=011, pass=1.
        start = 1'b1;
        tick();                                   // E0: previous results clear
        start = 1'b0;
        chk_all("t4.e0", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        vote_en = 3'b010; vote_val = 3'b010;
        tick();                                   // E1
        vote_en = 3'b010; vote_val = 3'b000;
        tick();                                   // E2: re-vote
        vote_en = 3'b001; vote_val = 3'b001;
        tick();                                   // E3
        vote_en = 3'b000;
        repeat (11) tick();                       // E4..E14
        chk({"t4.e14", ".done"}, {2'b0, done}, 3'b000);
        tick();                                   // E15
        chk_all("t4.done", 1'b1, 1'b1, 3'b011, 1'b1, 1'b1);
        tick();

        // Reset mid-COLLECT after two ballots: immediate clear, no done.
        start = 1'b1;
        tick();
        start = 1'b0;
        vote_en = 3'b011; vote_val = 3'b011;
        tick();
        vote_en = 3'b000;
        tick();
        chk_all("t5.pre", 1'b1, 1'b0, 3'b011, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t5.rst", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk_all("t5.wait", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        vote_en = 3'b111; vote_val = 3'b100;
        tick();
        vote_en = 3'b000;
        chk_all("t5.done", 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
        tick();

        // Third ballot lands on the E15 edge: counted, all-voted wins over timeout.
        start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        vote_en = 3'b011; vote_val = 3'b010;
        tick();                                   // E1
        vote_en = 3'b000;
        repeat (13) tick();                       // E2..E14
        vote_en = 3'b100; vote_val = 3'b100;
        tick();                                   // E15
        vote_en = 3'b000;
        chk_all("t6.done", 1'b1, 1'b1, 3'b111, 1'b1, 1'b0);
        tick();
        chk_all("t6.idle", 1'b0, 1'b0, 3'b111, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/majority_vote_ctrl.md
# majority_vote_ctrl

Session controller for the three-input majority voter. It opens a timed voting window on `start` and accepts at most one ballot from each of three voters. When all three have voted or the window expires, it evaluates the majority (two or more 1-ballots), reports the result with a one-cycle `done` strobe and holds `pass` until the next session. It sits between the voter input strobes and the result/display logic, and turns the combinational 2-of-3 vote into a sequenced, handshaken transaction.

## Interface
- `TIMEOUT`, default 15: maximum number of cycles spent in COLLECT; legal range 1..2^TW-1.
- `TW`, default 4: width of the window counter.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  opens a session; sampled only in IDLE.
- `vote_en`  input  3  per-voter ballot strobe; bit i belongs to voter i.
- `vote_val`  input  3  ballot value for voter i; valid only when `vote_en[i]`=1.
- `busy`  output  1  high in COLLECT and DONE.
- `voted`  output  3  bit i set once voter i's ballot has been accepted this session.
- `done`  output  1  one-cycle strobe: result valid.
- `pass`  output  1  majority result; held until the next accepted `start`.
- `timeout`  output  1  session ended with fewer than 3 ballots; held like `pass`.

## Operation
- States: IDLE, COLLECT, DONE. All outputs are registered or decoded from the state register, with no combinational path from inputs to outputs.
- Reset (async, `rst_n`=0):
  - state=IDLE; counter=0; ballot=0.
  - `voted`=0, `pass`=0, `timeout`=0, `busy`=0, `done`=0.
- IDLE:
  - `start`=1 → COLLECT.
  - On that edge: `voted`, ballot, `pass`, `timeout` and counter all clear to 0.
  - `vote_en` is ignored.
- COLLECT:
  - For each i with `vote_en[i]`=1 and `voted[i]`=0: ballot[i] ← `vote_val[i]`, `voted[i]` ← 1.
  - First ballot wins. A repeat `vote_en[i]` after acceptance is ignored, even with a different value.
  - Simultaneous strobes from several voters in one cycle are all accepted.
  - Counter increments by 1 each COLLECT cycle.
  - Exit to DONE on the edge where (`voted` | accepted-this-cycle) == 3'b111 **or** counter == TIMEOUT-1. If both hold on the same edge, the all-voted case takes precedence: `timeout`=0.
- Evaluation, registered on the COLLECT→DONE edge, using the ballots including those accepted on that same edge:
  - `pass` ← 1 iff popcount(ballot & voted) ≥ 2. Missing ballots count as 0.
  - `timeout` ← 1 iff final `voted` != 3'b111.
- DONE:
  - Lasts exactly one cycle; `done`=1 for that cycle; → IDLE.
  - `start` and `vote_en` are ignored.
- `start` during COLLECT or DONE is ignored; it is not queued.
- `pass`, `timeout` and `voted` hold their values in IDLE until the next accepted `start`.
- Arithmetic:
  - Popcount is 2 bits wide; the compare is ≥ 2'd2.
  - Counter is TW bits and never wraps, because the exit at TIMEOUT-1 precedes overflow.

## Timing
- Edge E0 samples `start`=1: `busy`=1 from E0 onward.
- Fastest session: all three ballots sampled at E1 → `done`=1 in the cycle after E1 → IDLE at E2, with `busy`=0 after E2. Start-to-done latency is 2 edges.
- Timeout path: with no full vote, COLLECT spans exactly TIMEOUT cycles and `done`=1 after edge E(TIMEOUT). For TIMEOUT=15, `done` follows E15 and IDLE is reached at E16.
- A ballot sampled on the exit edge is counted.
- `start` held high continuously: a new session is accepted at the first IDLE edge, giving a minimum of 1 IDLE cycle between sessions.
- Reset asserted mid-COLLECT or mid-DONE: all outputs clear immediately, with no `done` pulse. After deassertion the block waits in IDLE for `start`.

## Test plan
- Reset, then `start`; at E1 assert `vote_en`=111 with `vote_val`=011 → `done`=1 one cycle after E1, `pass`=1, `timeout`=0, `voted`=111.
- Ballots one per cycle: voter0=1, then voter1=0, then voter2=0 → `done` after the third ballot edge, `pass`=0, `timeout`=0.
- Only voters 0 and 2 vote, both 1; TIMEOUT=15 → `done` after E15, `pass`=1, `timeout`=1, `voted`=101.
- Voter1 votes 1, then re-strobes with 0, and voter0 votes 1 → the re-vote is ignored, `pass`=1, `voted`=011 at timeout, `timeout`=1.
- Reset pulse during COLLECT after two ballots → `voted`=000 and `busy`=0 at once, no `done`. The next session evaluates cleanly.
- `start` asserted during COLLECT and during DONE → no effect. `pass` from the previous session holds through IDLE and clears on the next accepted `start`.
